// File: rtl/lc3_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_pkg
// Purpose  : Shared definitions for the LC3 memory controller.
//            - Memory-mapped I/O register addresses (KBSR/KBDR/DSR/DDR)
//            - Access FSM state encoding
//            - Region-select encoding and the address decoder
// Revision : 1.0 - initial release
// ============================================================================
package lc3_mem_pkg;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SEL_RAM  = 3'd0,
        SEL_KBSR = 3'd1,
        SEL_KBDR = 3'd2,
        SEL_DSR  = 3'd3,
        SEL_DDR  = 3'd4,
        SEL_NONE = 3'd5
    } sel_t;

    // RAM occupies x0000 up to (but excluding) ram_limit. The limit is one
    // bit wider than the address so a full 64K-word RAM is expressible.
    function automatic sel_t decode_addr(input logic [15:0] addr,
                                         input logic [16:0] ram_limit);
        sel_t sel;
        if ({1'b0, addr} < ram_limit) begin
            sel = SEL_RAM;
        end else begin
            case (addr)
                KBSR_ADDR: sel = SEL_KBSR;
                KBDR_ADDR: sel = SEL_KBDR;
                DSR_ADDR:  sel = SEL_DSR;
                DDR_ADDR:  sel = SEL_DDR;
                default:   sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_kbd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : lc3_kbd_fifo
// Purpose  : Small keyboard character FIFO with asynchronous reset.
//            Push is ignored when full, pop is ignored when empty; a push and
//            a pop in the same cycle are both performed.
// Ports    : clk, rst            - clock, async active-high reset
//            push, push_data     - write a character
//            pop                 - discard the head entry
//            full, empty         - occupancy flags
//            head                - oldest entry (stale when empty)
// Params   : DEPTH (power of 2, >= 2), WIDTH
// Revision : 1.0 - initial release
// ============================================================================
module lc3_kbd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
    localparam logic [c_PTR_W:0]   c_CNT_ONE = 1;
    localparam logic [c_PTR_W:0]   c_FULL    = DEPTH[c_PTR_W:0];

    logic [WIDTH-1:0]   r_store [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);
    assign head      = r_store[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) r_store[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/lc3_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_ctrl
// Purpose  : LC3 memory-port subsystem. Decodes each CPU access to on-chip
//            RAM, the keyboard/display registers, or unmapped space, and
//            completes it with a one-cycle mem_ready pulse after
//            WAIT_STATES+1 cycles.
// Ports    : clk, rst                        - clock, async active-high reset
//            mem_en/we/addr/din              - CPU request (held until ready)
//            mem_dout, mem_ready             - response
//            kb_valid/kb_data/kb_ready       - keyboard handshake
//            disp_valid/disp_data/disp_ack   - display handshake
// Params   : ADDR_W (RAM = 2^ADDR_W words), WAIT_STATES (0..15),
//            KBD_DEPTH (FIFO depth, power of 2)
// Macro    : LC3_KBD_FIFO_EN - keyboard path becomes a KBD_DEPTH-entry FIFO;
//            otherwise a single KBSR/KBDR register pair.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 2,
    parameter int KBD_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_din,
    output logic [15:0] mem_dout,
    output logic        mem_ready,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ack
);

    localparam int          c_RAM_WORDS = 2 ** ADDR_W;
    localparam logic [16:0] c_RAM_LIMIT = 17'(c_RAM_WORDS);
    localparam logic [3:0]  c_WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_wait_cnt;
    logic [15:0] r_addr;
    logic [15:0] r_din;
    logic        r_we;
    sel_t        w_sel;

    logic        w_ram_wr;
    logic        w_kbdr_rd;
    logic        w_ddr_wr;
    logic [15:0] w_rdata;
    logic [15:0] r_dout_hold;

    logic [15:0] r_ram [c_RAM_WORDS];

    logic        w_kb_accept;
    logic        w_kbsr_bit;
    logic [7:0]  w_kbdr_char;

    logic        r_disp_valid;
    logic [7:0]  r_disp_data;

    assign w_sel = decode_addr(r_addr, c_RAM_LIMIT);

    // ------------------------------------------------------------------
    // Access FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // ------------------------------------------------------------------
    // Access FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (mem_en) w_next_state = (WAIT_STATES > 0) ? WAIT : RESP;
            WAIT:    if (r_wait_cnt == c_WAIT_LAST) w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Access FSM: outputs. All side effects commit on the edge that ends
    // RESP, so an async reset before that edge abandons the access.
    // ------------------------------------------------------------------
    always_comb begin
        mem_ready = 1'b0;
        w_ram_wr  = 1'b0;
        w_kbdr_rd = 1'b0;
        w_ddr_wr  = 1'b0;
        if (r_state == RESP) begin
            mem_ready = 1'b1;
            w_ram_wr  = r_we  && (w_sel == SEL_RAM);
            w_kbdr_rd = !r_we && (w_sel == SEL_KBDR);
            w_ddr_wr  = r_we  && (w_sel == SEL_DDR);
        end
    end

    // Request latch and wait-state counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_din      <= '0;
            r_we       <= 1'b0;
            r_wait_cnt <= '0;
        end else if (r_state == IDLE && mem_en) begin
            r_addr     <= mem_addr;
            r_din      <= mem_din;
            r_we       <= mem_we;
            r_wait_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // RAM: asynchronous read, write committed at the end of RESP
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_ram_wr) r_ram[r_addr[ADDR_W-1:0]] <= r_din;
    end

    // ------------------------------------------------------------------
    // Read data. The live value is shown during RESP and captured so that
    // mem_dout keeps the last response until the next one.
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = 16'h0000;
        case (w_sel)
            SEL_RAM:  w_rdata = r_ram[r_addr[ADDR_W-1:0]];
            SEL_KBSR: w_rdata = {w_kbsr_bit, 15'h0000};
            SEL_KBDR: w_rdata = {8'h00, w_kbdr_char};
            SEL_DSR:  w_rdata = {!r_disp_valid, 15'h0000};
            default:  w_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_dout_hold <= '0;
        else if (r_state == RESP) r_dout_hold <= w_rdata;
    end

    assign mem_dout = (r_state == RESP) ? w_rdata : r_dout_hold;

    // ------------------------------------------------------------------
    // Keyboard path
    // ------------------------------------------------------------------
    assign w_kb_accept = kb_valid && kb_ready;

`ifdef LC3_KBD_FIFO_EN
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic [7:0] w_fifo_head;

    lc3_kbd_fifo #(
        .DEPTH (KBD_DEPTH),
        .WIDTH (8)
    ) u_kbd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_kb_accept),
        .push_data (kb_data),
        .pop       (w_kbdr_rd),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .head      (w_fifo_head)
    );

    assign kb_ready    = !w_fifo_full;
    assign w_kbsr_bit  = !w_fifo_empty;
    // An empty FIFO reads as zero rather than exposing a stale slot.
    assign w_kbdr_char = w_fifo_empty ? 8'h00 : w_fifo_head;
`else
    logic       r_kbsr;
    logic [7:0] r_kbdr;

    // A new character beats the clear from a concurrent KBDR read; that
    // read already returned the old character from the live register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kbsr <= 1'b0;
            r_kbdr <= '0;
        end else if (w_kb_accept) begin
            r_kbsr <= 1'b1;
            r_kbdr <= kb_data;
        end else if (w_kbdr_rd) begin
            r_kbsr <= 1'b0;
        end
    end

    assign kb_ready    = !r_kbsr;
    assign w_kbsr_bit  = r_kbsr;
    assign w_kbdr_char = r_kbdr;
`endif

    // ------------------------------------------------------------------
    // Display path. DSR[15] is the complement of disp_valid. A DDR write
    // takes priority over a simultaneous disp_ack.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_valid <= 1'b0;
            r_disp_data  <= '0;
        end else if (w_ddr_wr) begin
            r_disp_valid <= 1'b1;
            r_disp_data  <= r_din[7:0];
        end else if (disp_ack && r_disp_valid) begin
            r_disp_valid <= 1'b0;
        end
    end

    assign disp_valid = r_disp_valid;
    assign disp_data  = r_disp_data;

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_mem_ctrl
// Purpose  : Self-checking bench for lc3_mem_ctrl. Expected read data is
//            queued when a request is issued and compared when mem_ready
//            returns it. Build with +define+LC3_KBD_FIFO_EN to cover the
//            keyboard FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3_mem_ctrl;

    localparam int c_ADDR_W = 12;
    localparam int c_WAITS  = 2;
    localparam int c_DEPTH  = 4;
    localparam int c_LAT    = c_WAITS + 1;
    localparam int c_BOUND  = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_en = 1'b0;
    logic        mem_we = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_din = '0;
    logic [15:0] mem_dout;
    logic        mem_ready;
    logic        kb_valid = 1'b0;
    logic [7:0]  kb_data = '0;
    logic        kb_ready;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ack = 1'b0;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];

    lc3_mem_ctrl #(
        .ADDR_W      (c_ADDR_W),
        .WAIT_STATES (c_WAITS),
        .KBD_DEPTH   (c_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mem_ready  (mem_ready),
        .kb_valid   (kb_valid),
        .kb_data    (kb_data),
        .kb_ready   (kb_ready),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ack   (disp_ack)
    );

    always #5 clk = ~clk;

    // One CPU access. lat = negedges from accept edge to mem_ready, -1 on
    // timeout. inj[0] offers kb char inj_kb and inj[1] pulses disp_ack in
    // the mem_ready cycle.
    task automatic bus_access(input logic we, input logic [15:0] addr, input logic [15:0] din,
                              input logic [1:0] inj, input logic [7:0] inj_kb,
                              output logic [15:0] rdata, output int lat);
        @(negedge clk);
        mem_en = 1'b1; mem_we = we; mem_addr = addr; mem_din = din;
        @(posedge clk);
        lat   = -1;
        rdata = 'x;
        for (int i = 1; i <= c_BOUND; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                lat   = i;
                rdata = mem_dout;
                if (inj[0]) begin kb_valid = 1'b1; kb_data = inj_kb; end
                if (inj[1]) disp_ack = 1'b1;
                break;
            end
        end
        mem_en = 1'b0;
        if (inj != 2'b00) begin
            @(posedge clk);
            #1;
            kb_valid = 1'b0;
            disp_ack = 1'b0;
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] din, output int lat);
        logic [15:0] d;
        bus_access(1'b1, addr, din, 2'b00, 8'h00, d, lat);
    endtask

    task automatic rd(input logic [15:0] addr, output logic [15:0] d, output int lat);
        bus_access(1'b0, addr, 16'h0000, 2'b00, 8'h00, d, lat);
    endtask

    task automatic test_reset();
        logic [15:0] d;
        int lat;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({mem_ready, mem_dout, kb_ready, disp_valid, disp_data} !== {1'b0, 16'h0000, 1'b1, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b dout=%h kb_ready=%b dvalid=%b ddata=%h, expected 0 0000 1 0 00",
                     mem_ready, mem_dout, kb_ready, disp_valid, disp_data);
        end
        rst = 1'b0;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h8000);
        rd(16'hFE00, d, lat);
        n_checks++;
        if (d !== exp_q[0]) begin n_fail++; $display("FAIL reset_kbsr: got %h expected %h", d, exp_q[0]); end
        void'(exp_q.pop_front());
        rd(16'hFE04, d, lat);
        n_checks++;
        if (d !== exp_q[0]) begin n_fail++; $display("FAIL reset_dsr: got %h expected %h", d, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_ram();
        logic [15:0] d, e;
        int lat;
        logic [15:0] a_tab [3] = '{16'h0010, 16'h0000, 16'h0FFF};
        logic [15:0] v_tab [3] = '{16'h1234, 16'hFFFF, 16'hABCD};
        for (int i = 0; i < 3; i++) begin
            wr(a_tab[i], v_tab[i], lat);
            n_checks++;
            if (lat !== c_LAT) begin n_fail++; $display("FAIL ram_write_latency[%0d]: got %0d expected %0d", i, lat, c_LAT); end
            exp_q.push_back(v_tab[i]);
        end
        for (int i = 0; i < 3; i++) begin
            rd(a_tab[i], d, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (lat !== c_LAT) begin n_fail++; $display("FAIL ram_read_latency[%0d]: got %0d expected %0d", i, lat, c_LAT); end
            n_checks++;
            if (d !== e) begin n_fail++; $display("FAIL ram_read[%h]: got %h expected %h", a_tab[i], d, e); end
        end
    endtask

    task automatic test_kbd();
        logic [15:0] d, e;
        int lat;
        logic [15:0] r_tab [3] = '{16'hFE00, 16'hFE02, 16'hFE00};
        @(negedge clk);
        n_checks++;
        if (kb_ready !== 1'b1) begin n_fail++; $display("FAIL kb_ready_idle: got %b expected 1", kb_ready); end
        kb_valid = 1'b1; kb_data = 8'h41;
        @(negedge clk);
        kb_valid = 1'b0;
`ifndef LC3_KBD_FIFO_EN
        n_checks++;
        if (kb_ready !== 1'b0) begin n_fail++; $display("FAIL kb_ready_held: got %b expected 0", kb_ready); end
        kb_valid = 1'b1; kb_data = 8'h42;
        repeat (2) @(negedge clk);
        kb_valid = 1'b0;
`endif
        wr(16'hFE00, 16'hFFFF, lat);
        exp_q.push_back(16'h8000);
        exp_q.push_back(16'h0041);
        exp_q.push_back(16'h0000);
        for (int i = 0; i < 3; i++) begin
            rd(r_tab[i], d, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (d !== e) begin n_fail++; $display("FAIL kbd_seq[%0d] %h: got %h expected %h", i, r_tab[i], d, e); end
        end
        @(negedge clk);
        n_checks++;
        if (kb_ready !== 1'b1) begin n_fail++; $display("FAIL kb_ready_return: got %b expected 1", kb_ready); end
        // KBDR read completing in the same cycle a new character arrives
`ifdef LC3_KBD_FIFO_EN
        exp_q.push_back(16'h0000);
`else
        exp_q.push_back(16'h0041);
`endif
        exp_q.push_back(16'h8000);
        exp_q.push_back(16'h005A);
        exp_q.push_back(16'h0000);
        bus_access(1'b0, 16'hFE02, 16'h0000, 2'b01, 8'h5A, d, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL kbdr_race_old: got %h expected %h", d, e); end
        for (int i = 0; i < 3; i++) begin
            rd(r_tab[i], d, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (d !== e) begin n_fail++; $display("FAIL kbd_race_seq[%0d] %h: got %h expected %h", i, r_tab[i], d, e); end
        end
    endtask

    task automatic test_display();
        logic [15:0] d, e;
        int lat;
        wr(16'hFE06, 16'h1258, lat);
        @(negedge clk);
        n_checks++;
        if ({disp_valid, disp_data} !== {1'b1, 8'h58}) begin
            n_fail++; $display("FAIL ddr_write: got valid=%b data=%h expected 1 58", disp_valid, disp_data);
        end
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        rd(16'hFE04, d, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL dsr_busy: got %h expected %h", d, e); end
        rd(16'hFE06, d, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL ddr_read: got %h expected %h", d, e); end
        // ack, then a stray ack and an ignored DSR write
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); disp_ack = 1'b1;
            @(negedge clk); disp_ack = 1'b0;
            n_checks++;
            if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL disp_ack[%0d]: got valid=%b expected 0", k, disp_valid); end
        end
        wr(16'hFE04, 16'h0000, lat);
        exp_q.push_back(16'h8000);
        rd(16'hFE04, d, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL dsr_ready: got %h expected %h", d, e); end
        // DDR write racing disp_ack: the write wins
        wr(16'hFE06, 16'h0059, lat);
        bus_access(1'b1, 16'hFE06, 16'h005A, 2'b10, 8'h00, d, lat);
        @(negedge clk);
        n_checks++;
        if ({disp_valid, disp_data} !== {1'b1, 8'h5A}) begin
            n_fail++; $display("FAIL ddr_ack_race: got valid=%b data=%h expected 1 5A", disp_valid, disp_data);
        end
        exp_q.push_back(16'h0000);
        rd(16'hFE04, d, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL dsr_after_race: got %h expected %h", d, e); end
        @(negedge clk); disp_ack = 1'b1;
        @(negedge clk); disp_ack = 1'b0;
    endtask

    task automatic test_unmapped();
        logic [15:0] d, e;
        int lat, bad;
        logic [15:0] bad_addr;
        logic [15:0] u_tab [5] = '{16'hC000, 16'h1000, 16'hFFFF, 16'hFE01, 16'hFE08};
        for (int a = 0; a < 4096; a++) begin
            wr(16'(a), 16'(a) ^ 16'hA5A5, lat);
            if (lat < 0) break;
        end
        wr(16'hC000, 16'hFFFF, lat);
        wr(16'h1000, 16'hFFFF, lat);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(16'h0000);
            rd(u_tab[i], d, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (lat !== c_LAT || d !== e) begin
                n_fail++; $display("FAIL unmapped_read[%h]: got %h lat %0d expected %h lat %0d", u_tab[i], d, lat, e, c_LAT);
            end
        end
        bad = 0;
        bad_addr = '0;
        for (int a = 0; a < 4096; a++) begin
            rd(16'(a), d, lat);
            if (d !== (16'(a) ^ 16'hA5A5)) begin
                if (bad == 0) bad_addr = 16'(a);
                bad++;
            end
            if (lat < 0) begin bad += 4096 - a; break; end
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL ram_unchanged: got %0d bad words (first %h) expected 0", bad, bad_addr); end
    endtask

    task automatic test_back_to_back();
        int pulses, first_at, second_at;
        logic [15:0] e;
        exp_q.push_back(16'h0005 ^ 16'hA5A5);
        exp_q.push_back(16'h0FFE ^ 16'hA5A5);
        pulses = 0; first_at = -1; second_at = -1;
        @(negedge clk);
        mem_en = 1'b1; mem_we = 1'b0; mem_addr = 16'h0005;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                pulses++;
                if (pulses == 1) begin first_at = i; mem_addr = 16'h0FFE; end
                if (pulses == 2) begin second_at = i; mem_en = 1'b0; end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if (mem_dout !== e) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", pulses, mem_dout, e); end
                end
            end
        end
        mem_en = 1'b0;
        n_checks++;
        if (pulses !== 2 || first_at !== c_LAT || second_at !== 2 * c_LAT + 1) begin
            n_fail++;
            $display("FAIL b2b_timing: got pulses=%0d at %0d,%0d expected 2 at %0d,%0d", pulses, first_at, second_at, c_LAT, 2 * c_LAT + 1);
        end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_pending: got %0d expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d, e;
        int lat, pulses;
        logic [15:0] r_tab [3] = '{16'h0020, 16'hFE04, 16'hFE00};
        wr(16'hFE06, 16'h0033, lat);
        @(negedge clk); kb_valid = 1'b1; kb_data = 8'h77;
        @(negedge clk); kb_valid = 1'b0;
        @(negedge clk);
        mem_en = 1'b1; mem_we = 1'b1; mem_addr = 16'h0020; mem_din = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; mem_en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_ready) pulses++;
            if (i == 1) rst = 1'b0;
        end
        n_checks++;
        if (pulses !== 0) begin n_fail++; $display("FAIL reset_mid_ready: got %0d pulses expected 0", pulses); end
        n_checks++;
        if ({disp_valid, kb_ready, mem_dout} !== {1'b0, 1'b1, 16'h0000}) begin
            n_fail++; $display("FAIL reset_mid_state: got dvalid=%b kb_ready=%b dout=%h expected 0 1 0000", disp_valid, kb_ready, mem_dout);
        end
        exp_q.push_back(16'h0020 ^ 16'hA5A5);
        exp_q.push_back(16'h8000);
        exp_q.push_back(16'h0000);
        for (int i = 0; i < 3; i++) begin
            rd(r_tab[i], d, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (d !== e) begin n_fail++; $display("FAIL reset_mid_read[%h]: got %h expected %h", r_tab[i], d, e); end
        end
    endtask

`ifdef LC3_KBD_FIFO_EN
    task automatic test_fifo();
        logic [15:0] d, e;
        int lat;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            kb_valid = 1'b1; kb_data = 8'h61 + 8'(i);
            @(negedge clk);
        end
        kb_valid = 1'b0;
        n_checks++;
        if (kb_ready !== 1'b0) begin n_fail++; $display("FAIL fifo_full: got kb_ready=%b expected 0", kb_ready); end
        kb_valid = 1'b1; kb_data = 8'h65;
        repeat (2) @(negedge clk);
        kb_valid = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h0061 + 16'(i));
        exp_q.push_back(16'h0000);
        for (int i = 0; i < 4; i++) begin
            rd(16'hFE02, d, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (d !== e) begin n_fail++; $display("FAIL fifo_order[%0d]: got %h expected %h", i, d, e); end
        end
        rd(16'hFE00, d, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL fifo_empty_kbsr: got %h expected %h", d, e); end
        // push and pop in the same cycle
        @(negedge clk); kb_valid = 1'b1; kb_data = 8'h70;
        @(negedge clk); kb_valid = 1'b0;
        exp_q.push_back(16'h0070);
        exp_q.push_back(16'h8000);
        exp_q.push_back(16'h0071);
        exp_q.push_back(16'h0000);
        bus_access(1'b0, 16'hFE02, 16'h0000, 2'b01, 8'h71, d, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL fifo_pushpop_head: got %h expected %h", d, e); end
        rd(16'hFE00, d, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL fifo_pushpop_kbsr: got %h expected %h", d, e); end
        rd(16'hFE02, d, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL fifo_pushpop_next: got %h expected %h", d, e); end
        rd(16'hFE00, d, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL fifo_final_kbsr: got %h expected %h", d, e); end
    endtask
`endif

    initial begin
        test_reset();
        test_ram();
        test_kbd();
        test_display();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
`ifdef LC3_KBD_FIFO_EN
        test_fifo();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lc3_mem_ctrl.md
Name: lc3_mem_ctrl

Overview:
- Memory subsystem on the LC3 CPU's memory port (MAR/MDR side, addr/din/dout/we).
- Decodes each access to one of: on-chip word RAM, the LC3 memory-mapped keyboard/display registers, or unmapped space.
- Returns read data through a ready (R) handshake with programmable wait states.
- Replaces the ad-hoc memory model currently used around the lc3 core.

Parameters:
- ADDR_W, 12, RAM address bits; RAM is 2^ADDR_W x 16 words at x0000..(2^ADDR_W-1).
- WAIT_STATES, 2, extra cycles between request accept and ready; legal range 0..15.
- KBD_DEPTH, 4, keyboard FIFO depth; power of 2; used only with LC3_KBD_FIFO_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_en  in  1  CPU access request; held high until mem_ready is seen.
- mem_we  in  1  1 = write, 0 = read; sampled on accept.
- mem_addr  in  16  word address; sampled on accept.
- mem_din  in  16  write data from MDR; sampled on accept.
- mem_dout  out  16  read data; valid in the mem_ready cycle, held until the next response.
- mem_ready  out  1  one-cycle completion pulse (LC3 "R").
- kb_valid  in  1  keyboard character offered.
- kb_data  in  8  keyboard character.
- kb_ready  out  1  keyboard character accepted this cycle when kb_valid & kb_ready.
- disp_valid  out  1  display character pending.
- disp_data  out  8  display character (DDR[7:0]).
- disp_ack  in  1  display consumed the character.

Behaviour:
- Reset values (async on rst=1):
  - FSM=IDLE, mem_ready=0, mem_dout=0.
  - KBSR[15]=0, KBDR=0, kb_ready=1.
  - DSR[15]=1, disp_valid=0, disp_data=0.
  - RAM contents undefined and not cleared.
- FSM states IDLE, WAIT, RESP:
  - IDLE & mem_en: latch addr/we/din; go to WAIT if WAIT_STATES>0, else RESP.
  - WAIT: 4-bit counter counts WAIT_STATES cycles, then RESP.
  - RESP: mem_ready=1, write committed, read data driven; next state IDLE.
- Latency: mem_ready rises WAIT_STATES+1 cycles after the accept edge.
- After RESP the FSM spends one cycle in IDLE; a mem_en still high in that cycle is a new request.
- Address decode (on latched address):
  - addr < 2^ADDR_W: RAM.
  - xFE00 KBSR (bit15 = char available, other bits read 0, writes ignored).
  - xFE02 KBDR (read = {8'h00, char}; read clears KBSR[15]; writes ignored).
  - xFE04 DSR (bit15 = display ready, writes ignored).
  - xFE06 DDR (write: disp_data=din[7:0], disp_valid=1, DSR[15]=0; reads 0).
  - All other addresses: reads return x0000, writes dropped, mem_ready still pulses.
- Keyboard without FIFO:
  - kb_ready = !KBSR[15].
  - Accept: KBDR=kb_data, KBSR[15]=1.
- Display:
  - disp_ack while disp_valid: disp_valid=0, DSR[15]=1.
  - disp_ack with disp_valid=0 is ignored.
- Simultaneous events:
  - KBDR read RESP and kb accept in the same cycle: the read returns the old char and the new char is latched; KBSR[15] ends at 1.
  - DDR write RESP and disp_ack in the same cycle: the write wins; disp_valid stays 1 with the new data and DSR[15]=0.
- DDR write while DSR[15]=0: overwrites the pending character. Software must poll DSR first.
- Reset mid-access: the access is abandoned, no write is committed, and no mem_ready pulse occurs.

Optional Feature:
- Macro LC3_KBD_FIFO_EN.
- Defined:
  - Keyboard path is a KBD_DEPTH-entry FIFO.
  - kb_ready = !full; KBSR[15] = !empty; KBDR read pops the head.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - Reset empties the FIFO.
- Undefined: single-register behaviour as above.

Decomposition:
- Package lc3_mem_pkg:
  - Address constants KBSR_ADDR=xFE00, KBDR_ADDR=xFE02, DSR_ADDR=xFE04, DDR_ADDR=xFE06.
  - FSM state enum {IDLE, WAIT, RESP}.
  - Region-select enum {SEL_RAM, SEL_KBSR, SEL_KBDR, SEL_DSR, SEL_DDR, SEL_NONE}.
- Sub-module lc3_kbd_fifo (push/pop/full/empty/head, async reset).
  - Instantiated only under LC3_KBD_FIFO_EN; otherwise the single register is inline.

Test Plan:
- Write x1234 to x0010, then read x0010 with WAIT_STATES=2 -> mem_ready exactly 3 cycles after each accept; read mem_dout=x1234.
- kb_valid with kb_data=x41 -> KBSR reads x8000; KBDR reads x0041; KBSR then reads x0000; kb_ready returns to 1.
- Write x0058 to xFE06 -> disp_valid=1, disp_data=x58, DSR reads x0000; after disp_ack DSR reads x8000 and disp_valid=0.
- Read xC000 (unmapped) -> mem_dout=x0000 with a mem_ready pulse; write xC000 then read x0000..xFFF -> RAM unchanged.
- Assert rst in WAIT of a write of xBEEF to x0020 -> no mem_ready; x0020 keeps its prior value; DSR=x8000, KBSR=x0000 after reset.
- LC3_KBD_FIFO_EN, KBD_DEPTH=4: push x61,x62,x63,x64 -> kb_ready=0; a fifth kb_valid is not accepted; KBDR reads return x0061..x0064 in order, then KBSR=x0000.
